// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM states, access size codes,
// the default I/O address prefix and the buffered load/store request record.
package mem_ctrl_pkg;

  typedef logic [31:0] data_t;

  localparam logic [1:0] IO_PREFIX_DEFAULT = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  typedef struct packed {
    logic       wr;
    data_t      addr;
    logic [2:0] size;
    data_t      data;
  } lsb_req_t;

  // Unsupported size codes fall back to a full word.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_BYTE: size_bytes = SIZE_BYTE;
      SIZE_HALF: size_bytes = SIZE_HALF;
      default:   size_bytes = SIZE_WORD;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input data_t word, input logic [1:0] idx);
    byte_of = word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// traffic onto a one-cycle-latency RAM port, with I/O back-pressure and flush.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        in_fetch_flag,
  input  logic [31:0] in_fetch_pc,
  output logic        out_fetch_flag,
  output logic [31:0] out_fetch_inst,
  input  logic        in_lsb_flag,
  input  logic        in_lsb_wr,
  input  logic [31:0] in_lsb_addr,
  input  logic [2:0]  in_lsb_size,
  input  logic [31:0] in_lsb_data,
  output logic        out_lsb_flag,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_xbp
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] len_q, len_d;
  data_t      base_q, base_d;
  data_t      wdata_q, wdata_d;
  logic       io_q, io_d;
  data_t      rd_buf_q, rd_buf_d;

  logic       pend_fetch_v_q, pend_fetch_v_d;
  data_t      pend_fetch_pc_q, pend_fetch_pc_d;
  logic       pend_lsb_v_q, pend_lsb_v_d;
  lsb_req_t   pend_lsb_q, pend_lsb_d;

  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        out_fetch_flag_q, out_fetch_flag_d;
  data_t       out_fetch_inst_q, out_fetch_inst_d;
  logic        out_lsb_flag_q, out_lsb_flag_d;
  data_t       out_lsb_data_q, out_lsb_data_d;

  logic [2:0] cnt_inc;
  logic [1:0] cap_idx;
  logic       free;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    base_d           = base_q;
    wdata_d          = wdata_q;
    io_d             = io_q;
    rd_buf_d         = rd_buf_q;
    pend_fetch_v_d   = pend_fetch_v_q;
    pend_fetch_pc_d  = pend_fetch_pc_q;
    pend_lsb_v_d     = pend_lsb_v_q;
    pend_lsb_d       = pend_lsb_q;
    mem_a_d          = mem_a_q;
    mem_dout_d       = mem_dout_q;
    mem_wr_d         = 1'b0;
    out_fetch_flag_d = out_fetch_flag_q;
    out_fetch_inst_d = out_fetch_inst_q;
    out_lsb_flag_d   = out_lsb_flag_q;
    out_lsb_data_d   = out_lsb_data_q;
    cnt_inc          = cnt_q + 3'd1;
    cap_idx          = cnt_q[1:0] - 2'd1;
    free             = 1'b0;

    if (rdy) begin
      out_fetch_flag_d = 1'b0;
      out_lsb_flag_d   = 1'b0;

      // A flush kills speculative reads but never a store.
      if (in_rob_xbp) begin
        pend_fetch_v_d = 1'b0;
        if (!pend_lsb_q.wr) pend_lsb_v_d = 1'b0;
      end
      if (in_fetch_flag && !in_rob_xbp) begin
        pend_fetch_v_d  = 1'b1;
        pend_fetch_pc_d = in_fetch_pc;
      end
      if (in_lsb_flag && (in_lsb_wr || !in_rob_xbp)) begin
        pend_lsb_v_d = 1'b1;
        pend_lsb_d   = '{wr: in_lsb_wr, addr: in_lsb_addr, size: in_lsb_size, data: in_lsb_data};
      end

      case (state_q)
        ST_IDLE: free = !in_rob_xbp;

        ST_FETCH, ST_LOAD: begin
          if (in_rob_xbp) begin
            state_d = ST_IDLE;
          end else begin
            // RAM answers one cycle after the address, so byte k lands two edges later.
            if (cnt_q != 3'd0) rd_buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
            if (cnt_q == len_q) begin
              state_d = ST_IDLE;
              free    = 1'b1;
              if (state_q == ST_FETCH) begin
                out_fetch_flag_d = 1'b1;
                out_fetch_inst_d = rd_buf_d;
              end else begin
                out_lsb_flag_d = 1'b1;
                out_lsb_data_d = rd_buf_d;
              end
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc < len_q) mem_a_d = base_q + {29'd0, cnt_inc};
            end
          end
        end

        ST_STORE: begin
          if (mem_wr_q) begin
            if (cnt_inc == len_q) begin
              state_d        = ST_IDLE;
              out_lsb_flag_d = 1'b1;
              free           = !in_rob_xbp;
            end else begin
              cnt_d      = cnt_inc;
              mem_a_d    = base_q + {29'd0, cnt_inc};
              mem_dout_d = byte_of(wdata_q, cnt_inc[1:0]);
              // I/O sinks get an idle cycle between bytes.
              mem_wr_d   = !io_q;
            end
          end else begin
            mem_wr_d = !io_q || !io_buffer_full;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (free) begin
        if (pend_lsb_v_d) begin
          pend_lsb_v_d = 1'b0;
          len_d        = size_bytes(pend_lsb_d.size);
          base_d       = pend_lsb_d.addr;
          mem_a_d      = pend_lsb_d.addr;
          cnt_d        = 3'd0;
          if (pend_lsb_d.wr) begin
            state_d    = ST_STORE;
            wdata_d    = pend_lsb_d.data;
            mem_dout_d = pend_lsb_d.data[7:0];
            io_d       = (pend_lsb_d.addr[17:16] == IO_PREFIX);
            mem_wr_d   = !io_d || !io_buffer_full;
          end else begin
            state_d  = ST_LOAD;
            io_d     = 1'b0;
            rd_buf_d = '0;
          end
        end else if (pend_fetch_v_d) begin
          pend_fetch_v_d = 1'b0;
          state_d        = ST_FETCH;
          len_d          = SIZE_WORD;
          base_d         = pend_fetch_pc_d;
          mem_a_d        = pend_fetch_pc_d;
          cnt_d          = 3'd0;
          io_d           = 1'b0;
          rd_buf_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      len_q            <= '0;
      base_q           <= '0;
      wdata_q          <= '0;
      io_q             <= 1'b0;
      rd_buf_q         <= '0;
      pend_fetch_v_q   <= 1'b0;
      pend_fetch_pc_q  <= '0;
      pend_lsb_v_q     <= 1'b0;
      pend_lsb_q       <= '0;
      mem_a_q          <= '0;
      mem_dout_q       <= '0;
      mem_wr_q         <= 1'b0;
      out_fetch_flag_q <= 1'b0;
      out_fetch_inst_q <= '0;
      out_lsb_flag_q   <= 1'b0;
      out_lsb_data_q   <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      len_q            <= len_d;
      base_q           <= base_d;
      wdata_q          <= wdata_d;
      io_q             <= io_d;
      rd_buf_q         <= rd_buf_d;
      pend_fetch_v_q   <= pend_fetch_v_d;
      pend_fetch_pc_q  <= pend_fetch_pc_d;
      pend_lsb_v_q     <= pend_lsb_v_d;
      pend_lsb_q       <= pend_lsb_d;
      mem_a_q          <= mem_a_d;
      mem_dout_q       <= mem_dout_d;
      mem_wr_q         <= mem_wr_d;
      out_fetch_flag_q <= out_fetch_flag_d;
      out_fetch_inst_q <= out_fetch_inst_d;
      out_lsb_flag_q   <= out_lsb_flag_d;
      out_lsb_data_q   <= out_lsb_data_d;
    end
  end

  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  assign mem_wr         = mem_wr_q;
  assign out_fetch_flag = out_fetch_flag_q;
  assign out_fetch_inst = out_fetch_inst_q;
  assign out_lsb_flag   = out_lsb_flag_q;
  assign out_lsb_data   = out_lsb_data_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter IO_PREFIX, default 2'b11, addr[17:16] value that marks an I/O address.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rdy  input  1  global enable; low freezes all state.
REQ-005 mem_din  input  8  RAM read byte.
REQ-006 mem_dout  output  8  RAM write byte.
REQ-007 mem_a  output  32  RAM byte address.
REQ-008 mem_wr  output  1  1 = write, 0 = read.
REQ-009 io_buffer_full  input  1  I/O sink cannot accept a byte.
REQ-010 in_fetch_flag  input  1  one-cycle fetch request pulse.
REQ-011 in_fetch_pc  input  32  fetch address, word aligned.
REQ-012 out_fetch_flag  output  1  one-cycle fetch-done pulse.
REQ-013 out_fetch_inst  output  32  fetched word, little-endian.
REQ-014 in_lsb_flag  input  1  one-cycle load/store request pulse.
REQ-015 in_lsb_wr  input  1  1 = store, 0 = load.
REQ-016 in_lsb_addr  input  32  byte address.
REQ-017 in_lsb_size  input  3  byte count: 1, 2 or 4.
REQ-018 in_lsb_data  input  32  store data, low bytes used.
REQ-019 out_lsb_flag  output  1  one-cycle load/store-done pulse.
REQ-020 out_lsb_data  output  32  load result, zero-extended, little-endian.
REQ-021 in_rob_xbp  input  1  misprediction flush.

Function
REQ-022 States: IDLE, FETCH, LOAD, STORE; 3-bit byte counter; one pending-request register per requester.
- Request pulses arriving in any state are latched into pending; at most one outstanding per requester.
REQ-023 IDLE arbitration: pending LSB beats pending fetch; a request pulse is eligible on the edge it arrives (no extra cycle).
REQ-024 LOAD/FETCH, request taken at edge 0:
- mem_a = addr+k, mem_wr = 0 after edge k, k = 0..n-1.
- Byte k captured from mem_din at edge k+2.
- Done flag and data high for exactly the one cycle after edge n+1 (n = 4 for fetch).
- State returns to IDLE at edge n+1.
REQ-025 STORE, taken at edge 0:
- mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1 after edge k.
- out_lsb_flag high for the cycle after edge n.
REQ-026 I/O store (addr[17:16] == IO_PREFIX): while io_buffer_full = 1, the counter holds and mem_wr = 0; an I/O store drives at most one byte per two cycles.
REQ-027 Outside an active store, mem_wr = 0 and mem_a holds its last value.
REQ-028 Flush (in_rob_xbp = 1 at an edge):
- Active or pending fetch and load are aborted; no done pulse is issued for them.
- State goes to IDLE.
- An active or pending store completes normally.
- Concurrent fetch or load request pulses are dropped; a concurrent store pulse is latched.
REQ-029 rdy = 0 at an edge: state, counters, pending registers and outputs hold, except mem_wr, which is forced to 0 for that cycle.
REQ-030 Address increments wrap modulo 2^32; size values other than 1, 2 or 4 are treated as 4.

Reset
REQ-031 rst_n low asynchronously forces:
- State IDLE; pending registers and counter cleared.
- mem_wr, out_fetch_flag and out_lsb_flag = 0.
- mem_a, mem_dout, out_fetch_inst and out_lsb_data = 0.
REQ-032 Reset asserted mid-transaction discards it; no done pulse follows release.

Structure
REQ-033 State encoding, size codes and IO_PREFIX live in the shared definitions header alongside DATA_TYPE.
REQ-034 Single module; no sub-module is required.

Verification
REQ-035 Fetch 0x1000, RAM holding 13,05,00,00 -> mem_a 0x1000..0x1003; out_fetch_inst = 0x00000513 after edge 5.
REQ-036 LSB load (4 B at 0x20) and fetch (0x0) pulsed on the same edge -> load done after edge 5; fetch starts at edge 5; fetch done after edge 10.
REQ-037 Store of 2 B, data 0xBEEF, to 0x40 -> mem_wr writes EF@0x40, then BE@0x41; out_lsb_flag after edge 2.
REQ-038 Store of 1 B to 0x30000, io_buffer_full held high for 3 cycles -> no write during those cycles; the byte is written on the first cycle after full drops.
REQ-039 in_rob_xbp during a fetch at byte 2 -> no out_fetch_flag; IDLE next cycle; a fetch issued the following cycle completes correctly.
REQ-040 rst_n pulsed low mid-load, and rdy low for 3 cycles mid-store -> all outputs 0 after reset; the store resumes with the same byte after rdy returns high.
